// File: rtl/min_max_capture_ctrl.sv
// ---------------------------------------------------------------------------
// min_max_capture_ctrl
// Sequencer for a min/max peak-detect datapath and the sample SRAM behind it.
// One SRAM word is written per decimation window (even windows = max,
// odd windows = min). Capture runs into a circular buffer until a trigger,
// then continues for a programmed number of windows before stopping.
//
// Ports
//   i_clk        system clock, rising edge
//   i_clr_n      asynchronous reset, active low
//   i_start      pulse: begin a capture (accepted in IDLE/DONE only)
//   i_abort      pulse: stop at once and return to IDLE (wins over start)
//   i_trig       trigger; only the first one seen in RUN is used
//   i_decim      samples per window (0 behaves as 1), sampled on start
//   i_depth      ring size in words (0 = 2^ADDR_W), sampled on start
//   i_post_cnt   windows closed after the trigger before stopping
//   o_en         datapath window reload (window start)
//   o_max_min    datapath select: 0 = max, 1 = min
//   o_dp_clr_n   datapath synchronous clear, active low
//   o_sram_we    SRAM write strobe, one cycle per word
//   o_sram_addr  SRAM write address
//   o_trig_addr  address of the first write after the trigger was latched
//   o_busy       capture in progress (PRIME/RUN/POST/DRAIN)
//   o_done       capture finished, held until start/abort/reset
// ---------------------------------------------------------------------------
module min_max_capture_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DIV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_clr_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_trig,
  input  logic [DIV_W-1:0]  i_decim,
  input  logic [ADDR_W-1:0] i_depth,
  input  logic [ADDR_W-1:0] i_post_cnt,
  output logic              o_en,
  output logic              o_max_min,
  output logic              o_dp_clr_n,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [ADDR_W-1:0] o_trig_addr,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_RUN, S_POST, S_DRAIN, S_DONE
  } state_t;

  localparam logic [DIV_W-1:0]  DIV_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            r_state;
  state_t            w_state_next;

  logic [DIV_W-1:0]  r_decim;
  logic [DIV_W-1:0]  r_wcnt;
  logic [ADDR_W-1:0] r_depth;
  logic [ADDR_W-1:0] r_post_rem;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_max_min;
  logic              r_first;     // next EN only opens window 0, no write
  logic              r_pipe0;     // close seen one cycle ago
  logic              r_we;        // close seen two cycles ago -> write now
  logic              r_trig_arm;  // trigger latched, waiting for next write
  logic              r_drain;     // second DRAIN cycle

  logic              w_en;
  logic              w_close;
  logic              w_we;
  logic              w_dp_clr_n;
  logic              w_busy;
  logic              w_done;

  // State register
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    w_en         = 1'b0;
    w_dp_clr_n   = 1'b1;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = S_PRIME;
      end
      S_PRIME: begin
        w_busy       = 1'b1;
        w_dp_clr_n   = 1'b0;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_en   = (r_wcnt == '0);
        if (i_trig) begin
          w_state_next = (r_post_rem == '0) ? S_DRAIN : S_POST;
        end
      end
      S_POST: begin
        w_busy = 1'b1;
        w_en   = (r_wcnt == '0);
        // Last counted close: stop issuing EN, let the pipe land its writes
        if (w_en && !r_first && (r_post_rem == ADDR_ONE)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (r_drain) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        if (i_start) w_state_next = S_PRIME;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (i_abort) begin
      w_state_next = S_IDLE;
      w_en         = 1'b0;
    end
  end

  assign w_close = w_en && !r_first;
  // Abort suppresses a write already sitting at the end of the pipe
  assign w_we    = r_we && !i_abort;

  // Counters, address generation and the two-stage write pipe
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_decim     <= DIV_ONE;
      r_wcnt      <= '0;
      r_depth     <= '0;
      r_post_rem  <= '0;
      r_addr      <= '0;
      r_trig_addr <= '0;
      r_max_min   <= 1'b0;
      r_first     <= 1'b0;
      r_pipe0     <= 1'b0;
      r_we        <= 1'b0;
      r_trig_arm  <= 1'b0;
      r_drain     <= 1'b0;
    end else if (i_abort) begin
      r_pipe0    <= 1'b0;
      r_we       <= 1'b0;
      r_trig_arm <= 1'b0;
      r_drain    <= 1'b0;
    end else if (w_state_next == S_PRIME) begin
      r_decim     <= (i_decim == '0) ? DIV_ONE : i_decim;
      r_depth     <= i_depth;
      r_post_rem  <= i_post_cnt;
      r_wcnt      <= '0;
      r_addr      <= '0;
      r_trig_addr <= '0;
      r_max_min   <= 1'b0;
      r_first     <= 1'b1;
      r_pipe0     <= 1'b0;
      r_we        <= 1'b0;
      r_trig_arm  <= 1'b0;
      r_drain     <= 1'b0;
    end else begin
      r_pipe0 <= w_close;
      r_we    <= r_pipe0;
      r_drain <= (r_state == S_DRAIN) && !r_drain;

      if (w_en) begin
        r_first   <= 1'b0;
        r_max_min <= !r_max_min;
      end

      if ((r_state == S_RUN) || (r_state == S_POST)) begin
        r_wcnt <= (r_wcnt == r_decim - DIV_ONE) ? '0 : r_wcnt + DIV_ONE;
      end

      if ((r_state == S_POST) && w_close) begin
        r_post_rem <= r_post_rem - ADDR_ONE;
      end

      // A depth of 0 makes depth-1 all ones, so the natural wrap applies
      if (w_we) begin
        r_addr <= (r_addr == r_depth - ADDR_ONE) ? '0 : r_addr + ADDR_ONE;
        if (r_trig_arm) begin
          r_trig_addr <= r_addr;
          r_trig_arm  <= 1'b0;
        end
      end

      // Arm after the write check so a write in the latch cycle is not taken
      if ((r_state == S_RUN) && i_trig) begin
        r_trig_arm <= 1'b1;
      end
    end
  end

  assign o_en        = w_en;
  assign o_max_min   = r_max_min;
  assign o_dp_clr_n  = w_dp_clr_n;
  assign o_sram_we   = w_we;
  assign o_sram_addr = r_addr;
  assign o_trig_addr = r_trig_addr;
  assign o_busy      = w_busy;
  assign o_done      = w_done;

endmodule
